// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter feeding a shared bank of SR flags. One requester's set/clear
// masks are captured per command and applied one cycle later while gnt pulses.
module sr_flag_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*NFLAGS-1:0]   set_mask,
  input  logic [NREQ*NFLAGS-1:0]   clr_mask,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic [NFLAGS-1:0]        q,
  output logic [NFLAGS-1:0]        qn
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [PW-1:0]       ptr_reg, ptr_next;
  logic [NFLAGS-1:0]   set_cap_reg, set_cap_next;
  logic [NFLAGS-1:0]   clr_cap_reg, clr_cap_next;
  logic [NFLAGS-1:0]   q_reg, q_next;
  logic [NFLAGS-1:0]   qn_reg, qn_next;
  logic [NREQ-1:0]     gnt_reg, gnt_next;
  logic                busy_reg, busy_next;

  // Round-robin search: first asserted req starting at ptr, wrapping modulo NREQ.
  logic [PW-1:0]       rr_win;
  logic [NREQ-1:0]     rr_onehot;
  logic [PW-1:0]       rr_ptr_after;
  logic [NFLAGS-1:0]   q_upd;

  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    rr_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        rr_win = PW'(idx);
      end
    end
  end

  assign rr_ptr_after = (rr_win == PW'(NREQ - 1)) ? '0 : rr_win + 1'b1;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign rr_onehot[gi] = (rr_win == PW'(gi));
    end
  endgenerate

  // SR update per flag: set-only sets, clear-only clears, both or neither hold.
  generate
    for (genvar gi = 0; gi < NFLAGS; gi++) begin : g_flag
      always_comb begin
        q_upd[gi] = q_reg[gi];
        if (set_cap_reg[gi] && !clr_cap_reg[gi])
          q_upd[gi] = 1'b1;
        else if (!set_cap_reg[gi] && clr_cap_reg[gi])
          q_upd[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    set_cap_next = set_cap_reg;
    clr_cap_next = clr_cap_reg;
    q_next       = q_reg;
    gnt_next     = '0;
    busy_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next   = APPLY;
          ptr_next     = rr_ptr_after;
          set_cap_next = set_mask[rr_win*NFLAGS +: NFLAGS];
          clr_cap_next = clr_mask[rr_win*NFLAGS +: NFLAGS];
          gnt_next     = rr_onehot;
          busy_next    = 1'b1;
        end
      end
      APPLY: begin
        state_next = IDLE;
        q_next     = q_upd;
      end
      default: state_next = IDLE;
    endcase
    qn_next = ~q_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      set_cap_reg <= '0;
      clr_cap_reg <= '0;
      q_reg       <= '0;
      qn_reg      <= '1;
      gnt_reg     <= '0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      set_cap_reg <= set_cap_next;
      clr_cap_reg <= clr_cap_next;
      q_reg       <= q_next;
      qn_reg      <= qn_next;
      gnt_reg     <= gnt_next;
      busy_reg    <= busy_next;
    end
  end

  assign gnt  = gnt_reg;
  assign busy = busy_reg;
  assign q    = q_reg;
  assign qn   = qn_reg;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: expected grant/flag results are queued as
// commands are driven and checked as each grant appears.
module tb_sr_flag_arbiter;

  localparam int NREQ   = 4;
  localparam int NFLAGS = 8;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*NFLAGS-1:0]  set_mask;
  logic [NREQ*NFLAGS-1:0]  clr_mask;
  logic [NREQ-1:0]         gnt;
  logic                    busy;
  logic [NFLAGS-1:0]       q;
  logic [NFLAGS-1:0]       qn;

  typedef struct {
    logic [NREQ-1:0]   gnt;
    logic [NFLAGS-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .set_mask (set_mask),
    .clr_mask (clr_mask),
    .gnt      (gnt),
    .busy     (busy),
    .q        (q),
    .qn       (qn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [NFLAGS-1:0] s, input logic [NFLAGS-1:0] c);
    set_mask[idx*NFLAGS +: NFLAGS] = s;
    clr_mask[idx*NFLAGS +: NFLAGS] = c;
    req[idx] = 1'b1;
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [NFLAGS-1:0] qv);
    exp_t e;
    e.gnt = g;
    e.q   = qv;
    sb.push_back(e);
  endtask

  // Wait for each grant (one IDLE cycle expected), compare it, then the flags.
  task automatic serve(input int n, input bit drop);
    int   waited;
    exp_t e;
    logic [NFLAGS-1:0] qn_exp;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (gnt == '0 && waited < 8);
      check("gnt_latency", waited, 1);
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
        return;
      end
      e = sb.pop_front();
      check("gnt", gnt, e.gnt);
      check("busy_apply", busy, 1);
      $display("grant observed %b expected %b", gnt, e.gnt);
      if (drop) req = req & ~gnt;
      @(negedge clk);
      qn_exp = ~e.q;
      check("q", q, e.q);
      check("qn", qn, qn_exp);
      check("gnt_idle", gnt, 0);
      check("busy_idle", busy, 0);
      $display("flags observed %h expected %h", q, e.q);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    set_mask = '0;
    clr_mask = '0;
    repeat (2) @(negedge clk);
    check("rst_q", q, 8'h00);
    check("rst_qn", qn, 8'hFF);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Single set, then clear.
    load(0, 8'h0F, 8'h00);
    push(4'b0001, 8'h0F);
    serve(1, 1'b1);
    load(0, 8'h00, 8'h05);
    push(4'b0001, 8'h0A);
    serve(1, 1'b1);

    // Set and clear together holds.
    load(1, 8'h03, 8'h03);
    push(4'b0010, 8'h0A);
    serve(1, 1'b1);

    // Reset mid-APPLY discards a captured set of all flags.
    load(0, 8'hFF, 8'h00);
    @(negedge clk);
    check("pre_rst_gnt", gnt, 4'b0001);
    rst = 1'b1;
    #1;
    check("async_q", q, 8'h00);
    check("async_qn", qn, 8'hFF);
    check("async_gnt", gnt, 0);
    check("async_busy", busy, 0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_q", q, 8'h00);
    check("post_rst_gnt", gnt, 0);

    // Fairness from ptr = 0 with all four requesting.
    for (int i = 0; i < NREQ; i++) load(i, 8'(1 << i), 8'h00);
    push(4'b0001, 8'h01);
    push(4'b0010, 8'h03);
    push(4'b0100, 8'h07);
    push(4'b1000, 8'h0F);
    serve(4, 1'b1);

    // Pointer wrap after requester 3, then 0/3 alternate with req held.
    load(0, 8'h10, 8'h00);
    load(3, 8'h00, 8'h10);
    push(4'b0001, 8'h1F);
    push(4'b1000, 8'h0F);
    push(4'b0001, 8'h1F);
    push(4'b1000, 8'h0F);
    serve(4, 1'b0);
    req = '0;

    // Non-winner masks are not applied until that requester is granted.
    load(0, 8'h80, 8'h00);
    load(2, 8'h00, 8'hFF);
    push(4'b0001, 8'h8F);
    push(4'b0100, 8'h00);
    serve(2, 1'b1);

    repeat (2) @(negedge clk);
    check("final_gnt", gnt, 0);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Shared SR-flag bank with a round-robin arbiter in front of it. Up to NREQ requesters each submit a set mask and a clear mask for an NFLAGS-wide bank of SR flip-flops. The arbiter grants one requester at a time and applies its masks with the team's SR semantics. The block sits between control agents and the common status/flag register they share, serialising conflicting set/clear traffic.

## Interface
- NREQ, 4, number of requesters (2..8)
- NFLAGS, 8, number of SR flags in the bank (1..32)
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  NREQ  per-requester request; held high until its gnt bit is seen
- set_mask  input  NREQ*NFLAGS  requester i's set mask in bits [i*NFLAGS +: NFLAGS]
- clr_mask  input  NREQ*NFLAGS  requester i's clear mask, same packing
- gnt  output  NREQ  one-hot grant pulse, registered
- busy  output  1  high while a captured command is pending (state APPLY)
- q  output  NFLAGS  flag bank state, registered
- qn  output  NFLAGS  complement of q, registered, always equal to ~q

## Operation
- FSM has two states, IDLE and APPLY.
  - IDLE: if req != 0, select a winner by round-robin and capture its set/clear masks into internal registers. Record the winner index and go to APPLY. If req == 0, stay in IDLE.
  - APPLY: assert gnt[winner] for this cycle only and assert busy. At the end of the cycle, update the flags and return to IDLE. The req input is ignored in this state.
- Round-robin:
  - Pointer ptr ranges 0..NREQ-1.
  - The winner is the first asserted req bit when searching ptr, ptr+1, … with wrap modulo NREQ.
  - On capture, ptr becomes winner+1 mod NREQ.
- Per-flag update for flag k, using captured masks S=set[k], R=clr[k]:
  - S=1, R=0: q[k]=1, qn[k]=0
  - S=0, R=1: q[k]=0, qn[k]=1
  - S=1, R=1: hold
  - S=0, R=0: hold
- Flags not addressed by the winning masks never change.
- Masks of non-winning requesters are never applied. Their req stays pending and they compete again in the next IDLE cycle.
- A requester must drop req, or change its masks for a new command, in the cycle after gnt. A req still high in the next IDLE cycle counts as a new command.
- Reset, including assertion mid-APPLY, asynchronously forces:
  - state = IDLE, ptr = 0, gnt = 0, busy = 0
  - q = all 0, qn = all 1
  - captured masks cleared; any pending command is discarded and not applied.

## Timing
- Edge t: req is sampled in IDLE and the masks are captured.
- Cycle after t: APPLY; gnt and busy are high.
- Edge t+1: q and qn update; the new value is visible in the cycle after t+1.
- Latency from the req-sampling edge to q updated is 2 edges.
- Maximum throughput is one command per 2 cycles. Back-to-back requests from different requesters are granted on alternate cycles.
- gnt is never high for more than 1 consecutive cycle and has at most 1 bit set.
- busy equals (state == APPLY). gnt is nonzero only when busy = 1.
- After rst deasserts, the first capture can occur on the first rising edge.
- No combinational path from any input to any output.

## Test plan
- Reset:
  - Stimulus: assert rst mid-APPLY with a captured set_mask = 0xFF.
  - Required: q = 0x00, qn = 0xFF, gnt = 0, busy = 0 immediately, without waiting for a clock edge; after release, no update is applied.
- Single set then clear:
  - Stimulus: req0 with set = 0x0F, clr = 0x00; then req0 with set = 0x00, clr = 0x05.
  - Required: q = 0x0F two edges after the first sample, then q = 0x0A; qn = ~q at every cycle.
- Both set and clear:
  - Stimulus: from q = 0x0A, req1 with set = 0x03, clr = 0x03.
  - Required: q stays 0x0A; gnt = 0b0010 for one cycle.
- Round-robin fairness:
  - Stimulus: from reset, all four req bits held high, each requester dropping req after its gnt.
  - Required: grant order 0, 1, 2, 3 on alternate cycles; then req = 0b1001 continuously gives order 0, 3, 0, 3.
- Non-winner isolation:
  - Stimulus: req0 with set = 0x80 and req2 with clr = 0xFF asserted together from ptr = 0.
  - Required: q bit 7 is set first; the clear is applied only after gnt[2], giving q = 0x00.
- Pointer wrap:
  - Stimulus: grant requester 3, then assert req = 0b1001.
  - Required: next gnt = 0b0001, and ptr wraps to 1.
